// File: rtl/toggle_hs_pkg.sv
// Shared types and constants for the toggle-handshake receiver.
package toggle_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/toggle_handshake_rx_sync_chain.sv
// Async-reset multi-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_chain
    import toggle_hs_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle request/acknowledge CDC link with a
// valid/ready output towards the local consumer.
module toggle_handshake_rx
    import toggle_hs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tog,
    input  logic [DATA_W-1:0] req_data,
    input  logic              rx_ready,
    input  logic              err_clr,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              ack_tog,
    output logic              busy,
    output logic [CNT_W-1:0]  evt_count,
    output logic              proto_err
);

    state_t state;
    state_t state_next;
    logic   req_sync;
    logic   req_seen;
    logic   change;
    logic   capture;
    logic   accept;
    logic   err_set;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tog),
        .q   (req_sync)
    );

    assign change = req_sync ^ req_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        accept     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (change) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // A toggle here is a sender violation; it stays pending for IDLE.
                err_set = change;
                if (rx_ready) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_seen  <= 1'b0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            rx_data   <= '0;
            ack_tog   <= 1'b0;
            evt_count <= '0;
            proto_err <= 1'b0;
        end else begin
            rx_valid <= (state_next == HOLD);
            busy     <= (state_next == HOLD);
            if (capture) begin
                rx_data  <= req_data;
                req_seen <= req_sync;
            end
            if (accept) begin
                ack_tog   <= ~ack_tog;
                evt_count <= evt_count + CNT_W'(1);
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end else if (err_clr) begin
                proto_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Randomized bench for toggle_handshake_rx against a queue/counter reference model.
module tb_toggle_handshake_rx;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DATA_W      = 8;

    logic              clk;
    logic              rst;
    logic              req_tog;
    logic [DATA_W-1:0] req_data;
    logic              rx_ready;
    logic              err_clr;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              ack_tog;
    logic              busy;
    logic [7:0]        evt_count;
    logic              proto_err;
    logic              rx_valid4;
    logic [DATA_W-1:0] rx_data4;
    logic              ack_tog4;
    logic              busy4;
    logic [3:0]        evt_count4;
    logic              proto_err4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: words in flight, accepted-transfer total, sticky error.
    logic [DATA_W-1:0] exp_q[$];
    int                acc_total = 0;
    bit                exp_err   = 1'b0;

    toggle_handshake_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .DATA_W      (DATA_W),
        .CNT_W       (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_tog   (req_tog),
        .req_data  (req_data),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .ack_tog   (ack_tog),
        .busy      (busy),
        .evt_count (evt_count),
        .proto_err (proto_err)
    );

    toggle_handshake_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .DATA_W      (DATA_W),
        .CNT_W       (4)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_tog   (req_tog),
        .req_data  (req_data),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .rx_valid  (rx_valid4),
        .rx_data   (rx_data4),
        .ack_tog   (ack_tog4),
        .busy      (busy4),
        .evt_count (evt_count4),
        .proto_err (proto_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_valid(output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            seen = rx_valid;
        end
        check("valid_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_after_accept();
        check("post_valid", 32'(rx_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("ack_tog", 32'(ack_tog), 32'(acc_total % 2));
        check("evt_count", 32'(evt_count), 32'(acc_total % 256));
        check("evt_count4", 32'(evt_count4), 32'(acc_total % 16));
        check("proto_err", 32'(proto_err), 32'(exp_err));
    endtask

    // One protocol-compliant transfer; called at a negedge, returns at a negedge.
    task automatic send_word(input logic [DATA_W-1:0] d, input int delay);
        int n;
        rx_ready = (delay == 0);
        req_data = d;
        req_tog  = ~req_tog;
        exp_q.push_back(d);
        wait_valid(n);
        check("latency", 32'(n), 32'(SYNC_STAGES + 1));
        check("rx_data", 32'(rx_data), 32'(exp_q[0]));
        check("busy", 32'(busy), 32'd1);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rx_valid), 32'd1);
            check("hold_data", 32'(rx_data), 32'(exp_q[0]));
        end
        rx_ready = 1'b1;
        @(negedge clk);
        acc_total++;
        void'(exp_q.pop_front());
        check_after_accept();
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        req_tog  = 1'b0;
        req_data = '0;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_ack", 32'(ack_tog), 32'd0);
        check("rst_count", 32'(evt_count), 32'd0);
        check("rst_err", 32'(proto_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single transfer, then the same word under long backpressure.
        send_word(8'hA5, 0);
        send_word(8'hA5, 10);

        // Ten back-to-back transfers with ready held high.
        for (int i = 0; i < 10; i++) begin
            send_word(8'(i), 0);
        end
        check("b2b_count", 32'(evt_count), 32'd12);
        check("b2b_ack", 32'(ack_tog), 32'd0);

        // Sender toggles again while the first word is still held.
        rx_ready = 1'b0;
        req_data = 8'h3C;
        req_tog  = ~req_tog;
        exp_q.push_back(8'h3C);
        wait_valid(n);
        check("err_first_data", 32'(rx_data), 32'h3C);
        req_data = 8'hC3;
        req_tog  = ~req_tog;
        exp_q.push_back(8'hC3);
        exp_err = 1'b1;
        repeat (3) @(negedge clk);
        check("err_set", 32'(proto_err), 32'd1);
        check("err_data_held", 32'(rx_data), 32'h3C);
        check("err_valid_held", 32'(rx_valid), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_set_wins", 32'(proto_err), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        acc_total++;
        void'(exp_q.pop_front());
        check_after_accept();
        rx_ready = 1'b0;
        @(negedge clk);
        check("err_second_valid", 32'(rx_valid), 32'd1);
        check("err_second_data", 32'(rx_data), 32'(exp_q[0]));
        rx_ready = 1'b1;
        @(negedge clk);
        acc_total++;
        void'(exp_q.pop_front());
        check_after_accept();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_cleared", 32'(proto_err), 32'd0);

        // Random data and ready delays; the 4-bit counter wraps along the way.
        for (int i = 0; i < 24; i++) begin
            send_word(8'($urandom), int'($urandom_range(0, 3)));
        end
        check("wrap_count4", 32'(evt_count4), 32'(acc_total % 16));

        // Asynchronous reset while a word is held.
        rx_ready = 1'b0;
        req_data = 8'h5A;
        req_tog  = ~req_tog;
        wait_valid(n);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(rx_valid), 32'd0);
        check("arst_data", 32'(rx_data), 32'd0);
        check("arst_ack", 32'(ack_tog), 32'd0);
        check("arst_count", 32'(evt_count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        req_tog = 1'b0;
        exp_q.delete();
        acc_total = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_word(8'h81, 1);
        send_word(8'h7E, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
